// File: rtl/multicycle_state_sequencer.sv
// Control FSM for the multi-cycle CPU: fetch strobes, per-opcode state walk,
// retire/illegal pulses and performance counters.
module multicycle_state_sequencer #(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [31:0]        instruction,
    input  logic               mem_ready,
    output logic [2:0]         state,
    output logic               fetch_ir_we,
    output logic               fetch_pc_we,
    output logic               retire,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count,
    output logic [COUNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        ST_ID   = 3'd0,
        ST_IF   = 3'd1,
        ST_EXEC = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        C_LW, C_SW, C_J, C_JAL, C_BR, C_ALU, C_JR, C_ILL
    } class_e;

    state_e             state_q, state_d;
    class_e             cls;
    logic [COUNT_W-1:0] instr_q, cycle_q;
    logic               fetch_s, retire_s, illegal_s;
    logic               run;

    logic [5:0] opcode, funct;
    assign opcode = instruction[31:26];
    assign funct  = instruction[5:0];

    always_comb begin
        cls = C_ILL;
        case (opcode)
            6'b100011: cls = C_LW;
            6'b101011: cls = C_SW;
            6'b000010: cls = C_J;
            6'b000011: cls = C_JAL;
            6'b000100,
            6'b000101: cls = C_BR;
            6'b001000,
            6'b001110: cls = C_ALU;
            6'b000000: begin
                case (funct)
                    6'b100000, 6'b100010, 6'b101010: cls = C_ALU;
                    6'b001000:                       cls = C_JR;
                    default:                         cls = C_ILL;
                endcase
            end
            default: cls = C_ILL;
        endcase
    end

    // Instruction class is re-decoded in every post-fetch state; a class that
    // has no business in the current state falls back to IF without retiring.
    always_comb begin
        state_d   = state_q;
        fetch_s   = 1'b0;
        retire_s  = 1'b0;
        illegal_s = 1'b0;
        case (state_q)
            ST_IF: begin
                if (mem_ready) begin
                    fetch_s = 1'b1;
                    state_d = ST_ID;
                end
            end
            ST_ID: begin
                if (cls == C_ILL) begin
                    illegal_s = 1'b1;
                    state_d   = ST_IF;
                end else if (cls == C_J) begin
                    retire_s = 1'b1;
                    state_d  = ST_IF;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (cls)
                    C_LW, C_SW, C_JAL, C_BR: state_d = ST_MEM;
                    C_ALU:                   state_d = ST_WB;
                    C_JR: begin
                        retire_s = 1'b1;
                        state_d  = ST_IF;
                    end
                    default:                 state_d = ST_IF;
                endcase
            end
            ST_MEM: begin
                case (cls)
                    C_LW: if (mem_ready) state_d = ST_WB;
                    C_SW: begin
                        if (mem_ready) begin
                            retire_s = 1'b1;
                            state_d  = ST_IF;
                        end
                    end
                    C_JAL: begin
                        retire_s = 1'b1;
                        state_d  = ST_IF;
                    end
                    C_BR:    state_d = ST_WB;
                    default: state_d = ST_IF;
                endcase
            end
            ST_WB: begin
                retire_s = 1'b1;
                state_d  = ST_IF;
            end
            default: state_d = ST_IF;
        endcase
    end

    // Strobes must also stay low while reset is held, even with mem_ready high.
    assign run         = en & rst_n;
    assign fetch_ir_we = run & fetch_s;
    assign fetch_pc_we = run & fetch_s;
    assign retire      = run & retire_s;
    assign illegal     = run & illegal_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IF;
            instr_q <= '0;
            cycle_q <= '0;
        end else if (en) begin
            state_q <= state_d;
            cycle_q <= cycle_q + COUNT_W'(1);
            if (retire_s) begin
                instr_q <= instr_q + COUNT_W'(1);
            end
        end
    end

    assign state       = state_q;
    assign instr_count = instr_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_multicycle_state_sequencer.sv
// Bench for multicycle_state_sequencer: per-opcode state paths from a table
// model, random wait/stall insertion, counter wrap on a 4-bit instance.
module tb_multicycle_state_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, en, mem_ready;
    logic [31:0] instruction;
    logic [2:0]  state, state4;
    logic        ir_we, pc_we, retire, illegal;
    logic        ir_we4, pc_we4, retire4, illegal4;
    logic [31:0] icnt, ccnt;
    logic [3:0]  icnt4, ccnt4;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned ecyc = 0;
    int unsigned einstr = 0;

    int path[4];
    int path_n;
    bit legal, memwait;

    always #5 clk = ~clk;

    multicycle_state_sequencer #(.COUNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .instruction(instruction),
        .mem_ready(mem_ready), .state(state), .fetch_ir_we(ir_we),
        .fetch_pc_we(pc_we), .retire(retire), .illegal(illegal),
        .instr_count(icnt), .cycle_count(ccnt)
    );

    multicycle_state_sequencer #(.COUNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .instruction(instruction),
        .mem_ready(mem_ready), .state(state4), .fetch_ir_we(ir_we4),
        .fetch_pc_we(pc_we4), .retire(retire4), .illegal(illegal4),
        .instr_count(icnt4), .cycle_count(ccnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural path table: states visited after fetch, per opcode/funct.
    task automatic decode_ref(input logic [31:0] ins);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        legal = 1; memwait = 0;
        path = '{0, 0, 0, 0};
        case (op)
            6'h23:        begin path = '{0, 2, 3, 4}; path_n = 4; memwait = 1; end
            6'h2B:        begin path = '{0, 2, 3, 0}; path_n = 3; memwait = 1; end
            6'h02:        begin path_n = 1; end
            6'h03:        begin path = '{0, 2, 3, 0}; path_n = 3; end
            6'h04, 6'h05: begin path = '{0, 2, 3, 4}; path_n = 4; end
            6'h08, 6'h0E: begin path = '{0, 2, 4, 0}; path_n = 3; end
            6'h00: begin
                if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A) begin
                    path = '{0, 2, 4, 0}; path_n = 3;
                end else if (fn == 6'h08) begin
                    path = '{0, 2, 0, 0}; path_n = 2;
                end else begin
                    path_n = 1; legal = 0;
                end
            end
            default: begin path_n = 1; legal = 0; end
        endcase
    endtask

    // One clock: drive at posedge+1, check at posedge+2, then advance the model.
    task automatic cyc(input logic e, input logic mr, input logic [31:0] ins,
                       input int est, input logic efetch, input logic eret,
                       input logic eill);
        en = e; mem_ready = mr; instruction = ins;
        #1;
        chk("state", 32'(state), 32'(est));
        chk("state4", 32'(state4), 32'(est));
        chk("fetch_ir_we", 32'(ir_we), 32'(efetch));
        chk("fetch_pc_we", 32'(pc_we), 32'(efetch));
        chk("retire", 32'(retire), 32'(eret));
        chk("illegal", 32'(illegal), 32'(eill));
        chk("instr_count", icnt, einstr);
        chk("cycle_count", ccnt, ecyc);
        chk("instr_count4", 32'(icnt4), einstr % 16);
        chk("cycle_count4", 32'(ccnt4), ecyc % 16);
        @(posedge clk);
        #1;
        if (e) begin
            ecyc++;
            if (eret) einstr++;
        end
    endtask

    task automatic maybe_stall(input int st, input logic [31:0] ins, input bit rnd,
                               input int stall_st, input int stall_n);
        int n;
        n = (st == stall_st) ? stall_n :
            ((rnd && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'($urandom), ins, st, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_instr(input logic [31:0] ins, input int if_w, input int mem_w,
                             input bit rnd, input int stall_st, input int stall_n);
        int st;
        bit last;
        logic mr;
        decode_ref(ins);
        for (int i = 0; i < if_w; i++)
            cyc(1'b1, 1'b0, $urandom, 1, 1'b0, 1'b0, 1'b0);
        maybe_stall(1, $urandom, rnd, stall_st, stall_n);
        cyc(1'b1, 1'b1, $urandom, 1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < path_n; k++) begin
            st = path[k];
            last = (k == path_n - 1);
            if (st == 3 && memwait)
                for (int w = 0; w < mem_w; w++)
                    cyc(1'b1, 1'b0, ins, 3, 1'b0, 1'b0, 1'b0);
            maybe_stall(st, ins, rnd, stall_st, stall_n);
            mr = (st == 3 && memwait) ? 1'b1 : 1'($urandom);
            cyc(1'b1, mr, ins, st, 1'b0, 1'(legal && last), 1'(!legal && st == 0));
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0] ops[8];
        logic [5:0] fns[5];
        ops = '{6'h23, 6'h2B, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0E};
        fns = '{6'h20, 6'h22, 6'h2A, 6'h08, 6'h21};
        r = $urandom;
        case ($urandom_range(0, 3))
            0: r[31:26] = ops[$urandom_range(0, 7)];
            1: begin r[31:26] = 6'h00; r[5:0] = fns[$urandom_range(0, 4)]; end
            2: r[31:26] = ops[$urandom_range(0, 7)];
            default: ;
        endcase
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b1; mem_ready = 1'b1; instruction = $urandom;
        @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd1);
        chk("rst_fetch", 32'(ir_we | pc_we), 32'd0);
        chk("rst_pulses", 32'(retire | illegal), 32'd0);
        chk("rst_counts", icnt | ccnt, 32'd0);
        ecyc = 0; einstr = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        run_instr(32'h8C220004, 0, 0, 0, -1, 0);
        chk("lw_instr_count", icnt, 32'd1);
        chk("lw_cycle_count", ccnt, 32'd5);
        run_instr(32'hAC220004, 0, 3, 0, -1, 0);
        run_instr(32'h08000010, 0, 0, 0, -1, 0);
        run_instr(32'h03E00008, 1, 0, 0, -1, 0);
        run_instr(32'h00221820, 0, 0, 0, -1, 0);
        run_instr(32'h14220003, 0, 2, 0, -1, 0);
        run_instr(32'hFC000000, 0, 0, 0, -1, 0);
        chk("ill_instr_count", icnt, 32'd6);
        run_instr(32'h20210001, 0, 0, 0, 2, 2);
        run_instr(32'h0C000004, 2, 1, 1, -1, 0);

        for (int n = 0; n < 60; n++)
            run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), 1, -1, 0);

        do_reset();
        for (int n = 0; n < 16; n++)
            run_instr(32'h08000000 | ($urandom & 32'h03FFFFFF), $urandom_range(0, 1), 0, 1, -1, 0);
        chk("wrap_instr_count4", 32'(icnt4), 32'd0);
        chk("wrap_instr_count", icnt, 32'd16);

        // Async reset while an ADD sits in EXEC.
        cyc(1'b1, 1'b1, $urandom, 1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 32'h00221820, 0, 1'b0, 1'b0, 1'b0);
        en = 1'b1; mem_ready = 1'b1; instruction = 32'h00221820;
        #1;
        chk("pre_rst_state", 32'(state), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'd1);
        chk("async_rst_state4", 32'(state4), 32'd1);
        chk("async_rst_counts", icnt | ccnt, 32'd0);
        chk("async_rst_counts4", 32'(icnt4 | ccnt4), 32'd0);
        chk("async_rst_pulses", 32'(retire | illegal | ir_we | pc_we), 32'd0);
        ecyc = 0; einstr = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr(32'h08000010, 0, 0, 0, -1, 0);
        chk("post_rst_instr_count", icnt, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
